// File: rtl/flag_unit_pkg.sv
// flag_unit_pkg: shared types and constants for the NZCV flag unit.
//   alu_op_e  - ALU opcode encoding (ADD/SUB/AND/ORR)
//   FLAG_*    - bit positions of N, Z, C, V within the 4-bit flags bus
//   nzcv_t    - packed flags struct, laid out {n,z,c,v} to match the bus
package flag_unit_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/flag_unit_flag_gen.sv
// flag_gen: combinational derivation of candidate NZCV from one ALU operation.
// Ports:
//   src_a, src_b  in  32  ALU operands
//   alu_result    in  32  ALU result for the same operation
//   alu_op        in  2   opcode (alu_op_e)
//   sh_carry      in  1   shifter carry-out, C for logical ops
//   v_old         in  1   current V, carried through for logical ops
//   flags         out 4   candidate {N,Z,C,V}
module flag_gen
    import flag_unit_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] alu_result,
    input  alu_op_e     alu_op,
    input  logic        sh_carry,
    input  logic        v_old,
    output nzcv_t       flags
);

    logic [32:0] sum_add;
    logic [32:0] sum_sub;

    always_comb begin
        sum_add = {1'b0, src_a} + {1'b0, src_b};
        // A + ~B + 1: carry-out is the "no borrow" flag
        sum_sub = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;

        flags.n = alu_result[31];
        flags.z = (alu_result == 32'd0);
        flags.c = sh_carry;
        flags.v = v_old;

        case (alu_op)
            ALU_ADD: begin
                flags.c = sum_add[32];
                flags.v = (src_a[31] == src_b[31]) & (alu_result[31] != src_a[31]);
            end
            ALU_SUB: begin
                flags.c = sum_sub[32];
                flags.v = (src_a[31] != src_b[31]) & (alu_result[31] != src_a[31]);
            end
            default: begin
                // logical ops: C from shifter, V untouched
                flags.c = sh_carry;
                flags.v = v_old;
            end
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: architectural NZCV register with a one-deep saved copy.
// Config macro: FLAG_UNIT_BYPASS_EN - when defined, Flags shows the value
// about to be written at the coming edge (combinational); otherwise Flags
// is the register output.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   Valid, CondEx         write qualifier (both needed to update)
//   SrcA, SrcB, ALUResult operands/result of the execute-stage op
//   ALUControl            opcode 00 ADD, 01 SUB, 10 AND, 11 ORR
//   ShCarry               shifter carry for logical ops
//   FlagWrite             [1] N/Z enable, [0] C/V enable
//   SaveFlags             copy NZCV -> saved
//   RestoreFlags          copy saved -> NZCV (overrides any write)
//   Flags                 {N,Z,C,V} to condition checker
//   SavedFlags            saved register contents
//   FlagsUpdated          high one cycle after any NZCV change
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Valid,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [31:0] ALUResult,
    input  logic [1:0]  ALUControl,
    input  logic        ShCarry,
    input  logic [1:0]  FlagWrite,
    input  logic        CondEx,
    input  logic        SaveFlags,
    input  logic        RestoreFlags,
    output logic [3:0]  Flags,
    output logic [3:0]  SavedFlags,
    output logic        FlagsUpdated
);

    nzcv_t nzcv_q, nzcv_d;
    nzcv_t saved_q, saved_d;
    logic  upd_q, upd_d;
    nzcv_t gen_flags;
    logic  wr;

    flag_gen u_flag_gen (
        .src_a      (SrcA),
        .src_b      (SrcB),
        .alu_result (ALUResult),
        .alu_op     (alu_op_e'(ALUControl)),
        .sh_carry   (ShCarry),
        .v_old      (nzcv_q.v),
        .flags      (gen_flags)
    );

    always_comb begin
        wr     = Valid & CondEx;
        nzcv_d = nzcv_q;
        if (RestoreFlags) begin
            nzcv_d = saved_q;
        end else if (wr) begin
            if (FlagWrite[1]) begin
                nzcv_d.n = gen_flags.n;
                nzcv_d.z = gen_flags.z;
            end
            if (FlagWrite[0]) begin
                nzcv_d.c = gen_flags.c;
                nzcv_d.v = gen_flags.v;
            end
        end
        // saved always takes the pre-edge NZCV, so save+restore swaps
        saved_d = SaveFlags ? nzcv_q : saved_q;
        upd_d   = (nzcv_d != nzcv_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q  <= nzcv_t'(RESET_FLAGS);
            saved_q <= nzcv_t'(RESET_FLAGS);
            upd_q   <= 1'b0;
        end else begin
            nzcv_q  <= nzcv_d;
            saved_q <= saved_d;
            upd_q   <= upd_d;
        end
    end

`ifdef FLAG_UNIT_BYPASS_EN
    // nzcv_d already encodes restore > write > hold, which is exactly the
    // forwarded view the condition checker needs.
    assign Flags = nzcv_d;
`else
    assign Flags = nzcv_q;
`endif
    assign SavedFlags   = saved_q;
    assign FlagsUpdated = upd_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed + randomized check of flag_unit against a
// behavioural model computed from the flag rules with plain arithmetic.
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Valid = 1'b0;
    logic [31:0] SrcA = '0, SrcB = '0, ALUResult = '0;
    logic [1:0]  ALUControl = '0;
    logic        ShCarry = 1'b0;
    logic [1:0]  FlagWrite = '0;
    logic        CondEx = 1'b0;
    logic        SaveFlags = 1'b0, RestoreFlags = 1'b0;
    logic [3:0]  Flags, SavedFlags;
    logic        FlagsUpdated;

    always #5 clk = ~clk;

    flag_unit #(.RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .Valid(Valid), .SrcA(SrcA), .SrcB(SrcB),
        .ALUResult(ALUResult), .ALUControl(ALUControl), .ShCarry(ShCarry),
        .FlagWrite(FlagWrite), .CondEx(CondEx), .SaveFlags(SaveFlags),
        .RestoreFlags(RestoreFlags), .Flags(Flags), .SavedFlags(SavedFlags),
        .FlagsUpdated(FlagsUpdated)
    );

    int vectors = 0;
    int errors  = 0;

    logic [3:0] m_flags = 4'b0000, m_saved = 4'b0000;
    logic       m_upd = 1'b0;
    logic [7:0] m_nx;
    logic       chk_en = 1'b0;

    // Candidate flags from arithmetic: carries from 64-bit unsigned sums,
    // overflow from signed range of the true result.
    function automatic logic [3:0] gen(input logic [1:0] op, input logic [31:0] a, b, r,
                                       input logic sc, input logic v_old);
        logic n, z, c, v;
        longint sa, sb, s;
        n = r[31];
        z = (r == 32'd0);
        c = sc;
        v = v_old;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'd0) begin
            c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 2'd1) begin
            c = (a >= b);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {n, z, c, v};
    endfunction

    function automatic logic [7:0] model_next(
        input logic [3:0] f, sv, input logic vld, ce, rs, sa_, input logic [1:0] fw, op,
        input logic [31:0] a, b, r, input logic sc);
        logic [3:0] nf, g;
        g  = gen(op, a, b, r, sc, f[0]);
        nf = f;
        if (rs) nf = sv;
        else if (vld && ce) begin
            if (fw[1]) nf[3:2] = g[3:2];
            if (fw[0]) nf[1:0] = g[1:0];
        end
        return {nf, sa_ ? f : sv};
    endfunction

    always_comb m_nx = model_next(m_flags, m_saved, Valid, CondEx, RestoreFlags, SaveFlags,
                                  FlagWrite, ALUControl, SrcA, SrcB, ALUResult, ShCarry);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags <= 4'b0000;
            m_saved <= 4'b0000;
            m_upd   <= 1'b0;
        end else begin
            m_upd   <= (m_nx[7:4] != m_flags);
            m_flags <= m_nx[7:4];
            m_saved <= m_nx[3:0];
        end
    end

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
`ifdef FLAG_UNIT_BYPASS_EN
            check("model_flags", Flags, m_nx[7:4]);
`else
            check("model_flags", Flags, m_flags);
`endif
            check("model_saved", SavedFlags, m_saved);
            check("model_upd", {3'b000, FlagsUpdated}, {3'b000, m_upd});
        end
    end

    // Apply inputs 1ns after a rising edge; they are sampled at the next one.
    task automatic set_in(input logic vld, ce, input logic [1:0] op, fw,
                          input logic [31:0] a, b, r, input logic sc, sv, rs);
        @(posedge clk);
        #1;
        Valid = vld; CondEx = ce; ALUControl = op; FlagWrite = fw;
        SrcA = a; SrcB = b; ALUResult = r; ShCarry = sc;
        SaveFlags = sv; RestoreFlags = rs;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 2'd0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Drive one op for one edge, return at the falling edge after it.
    task automatic run(input logic vld, ce, input logic [1:0] op, fw,
                       input logic [31:0] a, b, r, input logic sc, sv, rs);
        set_in(vld, ce, op, fw, a, b, r, sc, sv, rs);
        idle();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b, r;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_flags", Flags, 4'b0000);
        check("reset_saved", SavedFlags, 4'b0000);
        check("reset_upd", {3'b000, FlagsUpdated}, 4'b0000);
        chk_en = 1'b1;

        // reset arriving while an update is pending wins
        set_in(1'b1, 1'b1, 2'd0, 2'b11, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_flags", Flags, 4'b0000);
        check("rst_mid_upd", {3'b000, FlagsUpdated}, 4'b0000);

        // ADD overflow, plus same-cycle visibility depending on build
        set_in(1'b1, 1'b1, 2'd0, 2'b11, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
`ifdef FLAG_UNIT_BYPASS_EN
        check("bypass_same_cycle", Flags, 4'b1001);
`else
        check("reg_same_cycle", Flags, 4'b0000);
`endif
        idle();
        @(negedge clk);
        check("add_ovf", Flags, 4'b1001);
        check("add_upd", {3'b000, FlagsUpdated}, 4'b0001);
        @(negedge clk);
        check("add_upd_drop", {3'b000, FlagsUpdated}, 4'b0000);

        run(1'b1, 1'b1, 2'd1, 2'b11, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
        check("sub_eq", Flags, 4'b0110);
        run(1'b1, 1'b1, 2'd1, 2'b11, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        check("sub_lt", Flags, 4'b1000);

        run(1'b1, 1'b1, 2'd0, 2'b11, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        run(1'b1, 1'b1, 2'd2, 2'b11, 32'hF0, 32'h0F, 32'd0, 1'b1, 1'b0, 1'b0);
        check("and_keepv", Flags, 4'b0111);
        run(1'b1, 1'b0, 2'd2, 2'b11, 32'hF0, 32'h0F, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check("condfail_flags", Flags, 4'b0111);
        check("condfail_upd", {3'b000, FlagsUpdated}, 4'b0000);

        // build NZCV=0101, save it, then NZCV=1010, then swap with a pending write
        run(1'b1, 1'b1, 2'd0, 2'b11, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        run(1'b1, 1'b1, 2'd2, 2'b10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("half_nz", Flags, 4'b0101);
        run(1'b0, 1'b0, 2'd0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        run(1'b1, 1'b1, 2'd3, 2'b11, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        run(1'b1, 1'b1, 2'd1, 2'b01, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
        check("pre_swap_flags", Flags, 4'b1010);
        check("pre_swap_saved", SavedFlags, 4'b0101);
        run(1'b1, 1'b1, 2'd0, 2'b11, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        check("swap_flags", Flags, 4'b0101);
        check("swap_saved", SavedFlags, 4'b1010);

        // randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: a = 32'h7FFF_FFFF;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                3: a = 32'd0;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd1;
            case (op)
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd2: r = a & b;
                default: r = a | b;
            endcase
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), op,
                   2'($urandom_range(0, 3)), a, b, r, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
        end
        idle();
        @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
# flag_unit

Flag producer paired with the condition checker. It derives N, Z, C and V from the execute-stage operands and result, and holds them in the architectural NZCV register. It drives the 4-bit `Flags` bus {N,Z,C,V} that the condition checker evaluates, and it takes `CondEx` back so that a failed condition suppresses the flag update. It also keeps a one-deep saved-flags register used for exception entry and return.

## Interface
- `RESET_FLAGS`, default `4'b0000`: value of the NZCV register and of the saved register after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low (already decided).
- `Valid`  in  1  an execute-stage instruction is present this cycle.
- `SrcA`, `SrcB`  in  32  ALU operands.
- `ALUResult`  in  32  ALU result for the same instruction.
- `ALUControl`  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `ShCarry`  in  1  shifter carry-out, used as C for logical ops.
- `FlagWrite`  in  2  [1] enables the N/Z update; [0] enables the C/V update.
- `CondEx`  in  1  condition-pass result for the current instruction.
- `SaveFlags`  in  1  copy NZCV into the saved register.
- `RestoreFlags`  in  1  copy the saved register into NZCV.
- `Flags`  out  4  {N,Z,C,V} to the condition checker.
- `SavedFlags`  out  4  current contents of the saved register.
- `FlagsUpdated`  out  1  registered; high for 1 cycle after any NZCV change.

## Operation
- Write qualifier: `wr = Valid & CondEx`. `FlagWrite` bits are ignored when `wr` is 0.
- N = `ALUResult[31]`. Z = (`ALUResult` == 0).
- ADD: compute a 33-bit sum `{0,SrcA}+{0,SrcB}`.
  - C = sum[32].
  - V = (`SrcA[31]` == `SrcB[31]`) & (`ALUResult[31]` != `SrcA[31]`).
- SUB: computed as A + ~B + 1.
  - C = no-borrow, i.e. 1 when `SrcA` ≥ `SrcB` unsigned.
  - V = (`SrcA[31]` != `SrcB[31]`) & (`ALUResult[31]` != `SrcA[31]`).
- AND/ORR:
  - C = `ShCarry`.
  - V keeps its old value even when `FlagWrite[0]`=1.
- Update priority, highest first:
  1. `RestoreFlags`: NZCV ← saved, and the whole write is ignored.
  2. Otherwise, if `wr`: N/Z ← new values if `FlagWrite[1]`, and C/V ← new values if `FlagWrite[0]`. The two halves are independent.
- Save: `SaveFlags` captures NZCV as it stands before this edge's update.
  - Save and Restore in the same cycle swap the two registers.
  - Save and a write in the same cycle: saved gets the old flags, NZCV gets the new ones.
- `FlagsUpdated` is 1 the cycle after any edge where NZCV actually changed value.
- Reset:
  - NZCV = saved = `RESET_FLAGS`.
  - `FlagsUpdated` = 0.
  - Reset asserted mid-operation discards any in-flight update.

## Timing
- Flag register latency is 1 cycle. An update sampled at edge k is visible on `Flags` after edge k.
- Without bypass, an instruction at cycle k+1 sees the flags written by the instruction at cycle k. It never sees its own flags.
- `Flags` and `SavedFlags` are register outputs when bypass is disabled.
- `FlagsUpdated` is registered and asserts in cycle k+1 for a change at edge k.

## Configuration
- Macro: `FLAG_UNIT_BYPASS_EN`.
- Defined: `Flags` is combinational. While `wr` is 1 and `RestoreFlags` is 0, the bus shows the flags that will be written at the coming edge, merged per `FlagWrite` half. While `RestoreFlags` is 1 it shows `SavedFlags`. Otherwise it shows the register.
- Undefined: `Flags` is the register output only; there is no combinational path from inputs to `Flags`.
- The register update behaviour is identical in both builds.

## Structure
- Shared package:
  - ALU opcode enum (ADD/SUB/AND/ORR).
  - NZCV bit-index constants N=3, Z=2, C=1, V=0.
  - packed flags struct type.
- One natural sub-module, `flag_gen`: combinational NZCV derivation from operands, result, opcode and `ShCarry`.
- `flag_unit` keeps the registers, the priority logic, save/restore and the optional bypass.

## Test plan
- Reset with `RESET_FLAGS`=0 → `Flags`=0000, `SavedFlags`=0000, `FlagsUpdated`=0. Asserting `rst_n` mid-update keeps 0000.
- ADD 0x7FFFFFFF+1, result 0x80000000, `FlagWrite`=11, `CondEx`=1 → `Flags`=1001 next cycle; `FlagsUpdated`=1 for one cycle.
- SUB 5−5, result 0, `FlagWrite`=11 → `Flags`=0110. Then SUB 3−5, result 0xFFFFFFFE → `Flags`=1000.
- AND result 0 with `ShCarry`=1, `FlagWrite`=11, V previously 1 → `Flags`=0111. Repeat with `CondEx`=0 → flags unchanged and `FlagsUpdated`=0.
- NZCV=1010, saved=0101, `SaveFlags`=`RestoreFlags`=1 with a write pending → NZCV=0101, saved=1010; the write is dropped.
- Bypass build: ADD 0x7FFFFFFF+1 with `Valid`=`CondEx`=1 → `Flags`=1001 in the same cycle. Non-bypass build shows the old value until after the edge.
